// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: one imem request per PC, 2 cycles per fetch with zero-wait memory.
// Stall holds the PC and FetchValid in DONE; redirects are sampled only when DONE advances.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Stall,
  input  logic              Branch,
  input  logic [ADDR_W-1:0] BranchOffsetShifted,
  input  logic              Jump,
  input  logic [25:0]       JumpTarget26,
  input  logic              JumpReg,
  input  logic [ADDR_W-1:0] JumpRegAddr,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemAck,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus4,
  output logic              FetchValid,
  output logic              Misaligned
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misaligned_q, misaligned_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect priority: JumpReg > Jump > Branch > sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (JumpReg) begin
      next_pc = {JumpRegAddr[ADDR_W-1:2], 2'b00};
    end else if (Jump) begin
      next_pc = {pc_plus4[ADDR_W-1:28], JumpTarget26, 2'b00};
    end else if (Branch) begin
      next_pc = pc_plus4 + BranchOffsetShifted;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (ImemAck) state_d = S_DONE;
      end
      S_DONE: begin
        if (!Stall) begin
          pc_d    = next_pc;
          state_d = S_REQ;
          if (JumpReg && (JumpRegAddr[1:0] != 2'b00)) misaligned_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign ImemReq    = (state_q == S_REQ);
  assign ImemAddr   = pc_q;
  assign PC         = pc_q;
  assign PCPlus4    = pc_plus4;
  assign FetchValid = (state_q == S_DONE);
  assign Misaligned = misaligned_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage for the single-issue datapath.
- Consumes the word-aligned branch offset produced by the shift-left-by-2 stage.
- Forms the branch target, jump target, register-jump target and sequential next PC.
- Issues one instruction-memory request per PC through a req/ack handshake and presents the fetched PC to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width. Fixed at 32 for this design; the jump-target concatenation is defined for 32 only.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Stall  input  1  hold the current PC and keep FetchValid asserted.
- Branch  input  1  branch taken (resolved for the PC currently in DONE).
- BranchOffsetShifted  input  32  sign-extended offset already shifted left by 2.
- Jump  input  1  J/JAL-type redirect.
- JumpTarget26  input  26  instruction bits [25:0].
- JumpReg  input  1  JR-type redirect.
- JumpRegAddr  input  32  register value for JR.
- ImemReq  output  1  instruction-memory request.
- ImemAddr  output  32  request address; always equal to PC.
- ImemAck  input  1  memory accepted the request and returned data this cycle.
- PC  output  32  current fetch PC.
- PCPlus4  output  32  PC + 4, combinational from PC.
- FetchValid  output  1  fetch of PC complete; decode may consume it.
- Misaligned  output  1  sticky flag: a register jump targeted a non-word-aligned address.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - PC=RESET_PC, state=IDLE, ImemReq=0, FetchValid=0, Misaligned=0.
  - Asserting reset during REQ aborts the fetch immediately; a late ImemAck is ignored.
- FSM states IDLE, REQ, DONE:
  - IDLE: ImemReq=0. Goes to REQ on the next edge. The first request therefore appears one cycle after reset release.
  - REQ: ImemReq=1, ImemAddr=PC. Stays in REQ while ImemAck=0. When ImemAck=1, goes to DONE on that edge.
  - DONE: FetchValid=1.
    - Stall=1: stay in DONE with PC unchanged and FetchValid held at 1.
    - Stall=0: PC<=NextPC and go to REQ. Back-to-back throughput is therefore one fetch per 2 cycles with a zero-wait memory.
- NextPC priority, evaluated only in DONE with Stall=0: JumpReg > Jump > Branch > sequential.
  - Sequential: PCPlus4.
  - Branch: PCPlus4 + BranchOffsetShifted, modulo 2^32. Wrap-around is silent.
  - Jump: {PCPlus4[31:28], JumpTarget26, 2'b00}.
  - JumpReg: {JumpRegAddr[31:2], 2'b00}. If JumpRegAddr[1:0]!=0, Misaligned is set to 1 on that edge and stays 1 until reset.
- Redirect inputs (Branch, Jump, JumpReg) in IDLE or REQ are ignored. Stall in IDLE or REQ has no effect.
- ImemAck in IDLE or DONE is ignored.
- PCPlus4 wraps: PC=32'hFFFF_FFFC gives PCPlus4=32'h0000_0000.
- All outputs except PCPlus4 are driven from registered state. No combinational path exists from Branch, Jump or JumpReg to ImemReq.

Test Plan:
- Reset release with RESET_PC=0 and zero-wait ack -> ImemReq high at cycle 1 with ImemAddr=0. FetchValid at cycle 2. With no redirect, the next ImemAddr is 4, then 8.
- In DONE, PC=0x100, Branch=1, BranchOffsetShifted=0xFFFF_FFF0 -> next ImemAddr=0x0F4. With offset 0x40 -> next ImemAddr=0x144.
- PC=0x1000_0000, Jump=1, JumpTarget26=0x0000010, Branch=1 simultaneously -> next ImemAddr=0x1000_0040, because Jump beats Branch.
- JumpReg=1, JumpRegAddr=0x0000_2003, Jump=1 simultaneously -> next ImemAddr=0x2000. Misaligned=1 and stays 1 across later fetches until Rst_n=0.
- Hold ImemAck=0 for 5 cycles in REQ while toggling Branch, then Stall=1 for 3 cycles in DONE -> ImemAddr stable for all 5 cycles and the toggled Branch has no effect. FetchValid stays 1 for all 3 stall cycles and PC is unchanged. After Stall drops, PC advances by 4.
- Assert Rst_n=0 mid-REQ, then pulse ImemAck while in reset -> ImemReq=0 immediately and PC=RESET_PC. After release the FSM restarts from IDLE with no FetchValid from the aborted fetch.
